lin_evt_frame_master: RTL and testbench

Master-side handler for one LIN event-triggered frame slot, the counterpart of the slave-side event-triggered publisher. It sends the event-triggered header and classifies the response as silent, single publisher, or collision. On a collision it resolves by polling the two associated unconditional frames in turn. It sits between the master schedule table and the LIN master protocol core, which performs the header transmission and response reception.

---
 rtl/lin_evt_pkg.sv | 36 +++
 rtl/lin_pid_check.sv | 28 ++
 rtl/lin_evt_frame_master.sv | 157 +++++++++++++++
 tb/tb_lin_evt_frame_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lin_evt_pkg.sv
// ============================================================================
// lin_evt_pkg : shared types, status/result codes and PID parity helper
// Rev 1.0
// ============================================================================
`default_nettype none

package lin_evt_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EVT_HDR   = 3'd1,
    S_EVT_WAIT  = 3'd2,
    S_RES1_HDR  = 3'd3,
    S_RES1_WAIT = 3'd4,
    S_RES2_HDR  = 3'd5,
    S_RES2_WAIT = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  localparam logic [1:0] c_RSP_OK   = 2'b00;
  localparam logic [1:0] c_RSP_COLL = 2'b01;
  localparam logic [1:0] c_RSP_NONE = 2'b10;

  localparam logic [1:0] c_RES_NONE     = 2'b00;
  localparam logic [1:0] c_RES_SINGLE   = 2'b01;
  localparam logic [1:0] c_RES_RESOLVED = 2'b10;
  localparam logic [1:0] c_RES_ERROR    = 2'b11;

  // Returns {P1,P0} for a 6-bit frame identifier.
  function automatic logic [1:0] pid_parity(input logic [5:0] id);
    return {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/lin_pid_check.sv
// ============================================================================
// lin_pid_check : validates a publisher PID against the two associated frames
// Rev 1.0
// ============================================================================
`default_nettype none

module lin_pid_check
  import lin_evt_pkg::*;
#(
  parameter logic [5:0] UNCOND_FRAME1 = 6'h25,
  parameter logic [5:0] UNCOND_FRAME2 = 6'h26
) (
  input  logic [7:0] byte0_i,
  output logic       pid_ok_o,
  output logic [5:0] id_o
);

  logic w_par_ok;
  logic w_id_ok;

  assign id_o     = byte0_i[5:0];
  assign w_par_ok = (byte0_i[7:6] == pid_parity(byte0_i[5:0]));
  assign w_id_ok  = (byte0_i[5:0] == UNCOND_FRAME1) || (byte0_i[5:0] == UNCOND_FRAME2);
  assign pid_ok_o = w_par_ok && w_id_ok;

endmodule

`default_nettype wire

// File: rtl/lin_evt_frame_master.sv
// ============================================================================
// lin_evt_frame_master : master handler for one event-triggered frame slot
// Rev 1.0
// ============================================================================
`default_nettype none

module lin_evt_frame_master
  import lin_evt_pkg::*;
#(
  parameter logic [5:0] EVT_FRAME_ID  = 6'h10,
  parameter logic [5:0] UNCOND_FRAME1 = 6'h25,
  parameter logic [5:0] UNCOND_FRAME2 = 6'h26,
  parameter int         TIMEOUT_CYC   = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       evt_start_i,
  output logic       hdr_req_o,
  output logic [5:0] hdr_id_o,
  input  logic       hdr_ack_i,
  input  logic       rsp_valid_i,
  input  logic [1:0] rsp_status_i,
  input  logic [7:0] rsp_byte0_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic [5:0] src_id_o,
  output logic [1:0] resolved_mask_o,
  output logic [7:0] collision_cnt_o
);

  localparam int              TW         = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0]   c_TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        state_q;
  logic [TW-1:0] tmo_q;
  logic          hdr_req_q, busy_q, done_q;
  logic [5:0]    hdr_id_q, src_id_q;
  logic [1:0]    result_q, mask_q;
  logic [7:0]    coll_cnt_q;

  logic          w_pid_ok;
  logic [5:0]    w_pid_id;
  logic          w_rsp;
  logic [1:0]    w_status;
  logic          w_ok;

  lin_pid_check #(
    .UNCOND_FRAME1(UNCOND_FRAME1),
    .UNCOND_FRAME2(UNCOND_FRAME2)
  ) u_pid_check (
    .byte0_i (rsp_byte0_i),
    .pid_ok_o(w_pid_ok),
    .id_o    (w_pid_id)
  );

  // An expired wait is handled exactly like a "no response" status.
  assign w_rsp    = rsp_valid_i || (tmo_q == c_TMO_LAST);
  assign w_status = rsp_valid_i ? rsp_status_i : c_RSP_NONE;
  assign w_ok     = (w_status == c_RSP_OK);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      hdr_req_q  <= 1'b0;
      hdr_id_q   <= 6'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= c_RES_NONE;
      src_id_q   <= 6'd0;
      mask_q     <= 2'b00;
      coll_cnt_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (evt_start_i) begin
            state_q   <= S_EVT_HDR;
            hdr_req_q <= 1'b1;
            hdr_id_q  <= EVT_FRAME_ID;
            busy_q    <= 1'b1;
            result_q  <= c_RES_NONE;
            src_id_q  <= 6'd0;
            mask_q    <= 2'b00;
          end
        end
        S_EVT_HDR, S_RES1_HDR, S_RES2_HDR: begin
          tmo_q <= '0;
          if (hdr_ack_i) begin
            hdr_req_q <= 1'b0;
            hdr_id_q  <= 6'd0;
            state_q   <= (state_q == S_EVT_HDR)  ? S_EVT_WAIT  :
                         (state_q == S_RES1_HDR) ? S_RES1_WAIT : S_RES2_WAIT;
          end
        end
        S_EVT_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (w_rsp) begin
            if (w_status == c_RSP_COLL) begin
              if (coll_cnt_q != 8'hFF) coll_cnt_q <= coll_cnt_q + 8'd1;
              state_q   <= S_RES1_HDR;
              hdr_req_q <= 1'b1;
              hdr_id_q  <= UNCOND_FRAME1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (!w_ok) begin
                result_q <= c_RES_NONE;
              end else if (w_pid_ok) begin
                result_q <= c_RES_SINGLE;
                src_id_q <= w_pid_id;
              end else begin
                result_q <= c_RES_ERROR;
              end
            end
          end
        end
        S_RES1_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (w_rsp) begin
            mask_q[0] <= w_ok;
            state_q   <= S_RES2_HDR;
            hdr_req_q <= 1'b1;
            hdr_id_q  <= UNCOND_FRAME2;
          end
        end
        S_RES2_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (w_rsp) begin
            mask_q[1] <= w_ok;
            result_q  <= (w_ok || mask_q[0]) ? c_RES_RESOLVED : c_RES_ERROR;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hdr_req_o       = hdr_req_q;
  assign hdr_id_o        = hdr_id_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign result_o        = result_q;
  assign src_id_o        = src_id_q;
  assign resolved_mask_o = mask_q;
  assign collision_cnt_o = coll_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_lin_evt_frame_master.sv
// ============================================================================
// tb_lin_evt_frame_master : directed self-checking bench for the slot handler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lin_evt_frame_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       evt_start, hdr_ack, rsp_valid;
  logic [1:0] rsp_status;
  logic [7:0] rsp_byte0;
  logic       hdr_req, busy, done;
  logic [5:0] hdr_id, src_id;
  logic [1:0] result, mask;
  logic [7:0] coll_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lin_evt_frame_master dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .evt_start_i    (evt_start),
    .hdr_req_o      (hdr_req),
    .hdr_id_o       (hdr_id),
    .hdr_ack_i      (hdr_ack),
    .rsp_valid_i    (rsp_valid),
    .rsp_status_i   (rsp_status),
    .rsp_byte0_i    (rsp_byte0),
    .busy_o         (busy),
    .done_o         (done),
    .result_o       (result),
    .src_id_o       (src_id),
    .resolved_mask_o(mask),
    .collision_cnt_o(coll_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_slot();
    evt_start = 1'b1;
    step();
    evt_start = 1'b0;
    chk("start_req", hdr_req, 1);
    chk("start_busy", busy, 1);
  endtask

  task automatic do_hdr(input logic [5:0] id);
    int n = 0;
    while (!hdr_req && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("hdr_wait", 0, 1);
    chk("hdr_id", hdr_id, id);
    hdr_ack = 1'b1;
    step();
    hdr_ack = 1'b0;
    chk("hdr_drop", hdr_req, 0);
  endtask

  task automatic do_rsp(input logic [1:0] st, input logic [7:0] b0);
    rsp_valid  = 1'b1;
    rsp_status = st;
    rsp_byte0  = b0;
    step();
    rsp_valid  = 1'b0;
  endtask

  // Checks the completion pulse right after the final response edge.
  task automatic end_slot(input logic [1:0] res, input logic [5:0] sid,
                          input logic [1:0] msk, input logic [7:0] cnt);
    chk("done_hi", done, 1);
    chk("busy_hold", busy, 1);
    chk("result", result, res);
    chk("src_id", src_id, sid);
    chk("mask", mask, msk);
    chk("coll_cnt", coll_cnt, cnt);
    step();
    chk("done_lo", done, 0);
    chk("busy_lo", busy, 0);
  endtask

  task automatic coll_slot(input logic [1:0] s1, input logic [1:0] s2);
    start_slot();
    do_hdr(6'h10);
    do_rsp(2'b01, 8'h00);
    do_hdr(6'h25);
    do_rsp(s1, 8'h25);
    do_hdr(6'h26);
    do_rsp(s2, 8'hA6);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; evt_start = 1'b0; hdr_ack = 1'b0; rsp_valid = 1'b0;
    rsp_status = 2'b00; rsp_byte0 = 8'h00;
    step(); step();
    reset = 1'b0;
    chk("rst_req", hdr_req, 0);
    chk("rst_id", hdr_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cnt", coll_cnt, 0);

    // stray rsp_valid/hdr_ack in IDLE do nothing
    rsp_valid = 1'b1; hdr_ack = 1'b1;
    step();
    rsp_valid = 1'b0; hdr_ack = 1'b0;
    step();
    chk("ign_busy", busy, 0);
    chk("ign_done", done, 0);

    // single publisher, ID 0x25 -> PID 0x25
    start_slot();
    do_hdr(6'h10);
    do_rsp(2'b00, 8'h25);
    end_slot(2'b01, 6'h25, 2'b00, 8'd0);
    step();
    chk("res_hold", result, 2'b01);

    // result cleared at start; repeated evt_start ignored; ID 0x26 -> PID 0xA6
    start_slot();
    chk("clr_res", result, 0);
    chk("clr_src", src_id, 0);
    evt_start = 1'b1; step(); evt_start = 1'b0;
    do_hdr(6'h10);
    evt_start = 1'b1; step(); evt_start = 1'b0;
    chk("ign_start", hdr_req, 0);
    do_rsp(2'b00, 8'hA6);
    end_slot(2'b01, 6'h26, 2'b00, 8'd0);

    coll_slot(2'b00, 2'b00);
    end_slot(2'b10, 6'h00, 2'b11, 8'd1);
    coll_slot(2'b10, 2'b00);
    end_slot(2'b10, 6'h00, 2'b10, 8'd2);
    coll_slot(2'b10, 2'b10);
    end_slot(2'b11, 6'h00, 2'b00, 8'd3);

    // bad parity on ID 0x25
    start_slot(); do_hdr(6'h10); do_rsp(2'b00, 8'h65);
    end_slot(2'b11, 6'h00, 2'b00, 8'd3);
    // correct parity but ID 0x10 is not an associated frame
    start_slot(); do_hdr(6'h10); do_rsp(2'b00, 8'h50);
    end_slot(2'b11, 6'h00, 2'b00, 8'd3);
    // explicit no response
    start_slot(); do_hdr(6'h10); do_rsp(2'b10, 8'h25);
    end_slot(2'b00, 6'h00, 2'b00, 8'd3);

    // timeout in EVT_WAIT: done arrives 1024 edges after the ack edge
    start_slot();
    do_hdr(6'h10);
    n = 0;
    while (!done && n < 1100) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 1024);
    end_slot(2'b00, 6'h00, 2'b00, 8'd3);

    // reset while in RES1_WAIT
    start_slot();
    do_hdr(6'h10);
    do_rsp(2'b01, 8'h00);
    do_hdr(6'h25);
    chk("pre_rst_cnt", coll_cnt, 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_req", hdr_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cnt", coll_cnt, 0);
    chk("mid_rst_res", result, 0);
    chk("mid_rst_mask", mask, 0);
    step();
    chk("mid_rst_nodone", done, 0);

    // saturation of the collision counter
    for (int i = 0; i < 255; i++) begin
      coll_slot(2'b10, 2'b10);
      step();
    end
    chk("sat_255", coll_cnt, 255);
    coll_slot(2'b10, 2'b10);
    end_slot(2'b11, 6'h00, 2'b00, 8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
